// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: key conditioning, A/op/B entry FSM and the arithmetic unit
// (single-cycle add/sub/mul, iterative restoring divide).
module calc_seq_ctrl #(
   parameter int unsigned WIDTH      = 4,
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_number,
   input  logic [1:0]         op_sel,
   input  logic               k_enter,
   input  logic               k_clr,
   output logic [2*WIDTH-1:0] disp_data,
   output logic [2:0]         led,
   output logic               busy,
   output logic               neg,
   output logic               err
);
   localparam int unsigned RW  = 2 * WIDTH;
   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);

   // Encodings double as the led pattern.
   typedef enum logic [2:0] {
      StA    = 3'b001,
      StOp   = 3'b010,
      StB    = 3'b011,
      StExec = 3'b100,
      StShow = 3'b101
   } state_e;

   logic           enter_meta_q, enter_sync_q, clr_meta_q, clr_sync_q;
   logic           deb_level_q, press_q, deb_toggle;
   logic [DCW-1:0] deb_cnt_q;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d;
   logic [1:0]        op_q, op_d;
   logic [RW-1:0]     result_q, result_d, disp_q, disp_d;
   logic              neg_q, neg_d, err_q, err_d;
   logic [CW-1:0]     div_cnt_q, div_cnt_d;
   logic [WIDTH:0]    div_shift, div_sub;

   // Count consecutive samples disagreeing with the debounced level; any agreement restarts.
   assign deb_toggle = (enter_sync_q != deb_level_q) && (deb_cnt_q == DCW'(DEB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enter_meta_q <= 1'b0;
         enter_sync_q <= 1'b0;
         clr_meta_q   <= 1'b0;
         clr_sync_q   <= 1'b0;
         deb_level_q  <= 1'b0;
         deb_cnt_q    <= '0;
         press_q      <= 1'b0;
      end else begin
         enter_meta_q <= k_enter;
         enter_sync_q <= enter_meta_q;
         clr_meta_q   <= k_clr;
         clr_sync_q   <= clr_meta_q;
         if ((enter_sync_q == deb_level_q) || deb_toggle) deb_cnt_q <= '0;
         else deb_cnt_q <= deb_cnt_q + DCW'(1);
         if (deb_toggle) deb_level_q <= ~deb_level_q;
         press_q <= deb_toggle & ~deb_level_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      result_d  = result_q;
      neg_d     = neg_q;
      err_d     = err_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      div_cnt_d = div_cnt_q;
      div_shift = {rem_q, quo_q[WIDTH-1]};
      div_sub   = div_shift - {1'b0, b_q};
      if (clr_sync_q) begin
         state_d  = StA;
         a_d      = '0;
         b_d      = '0;
         op_d     = '0;
         result_d = '0;
         neg_d    = 1'b0;
         err_d    = 1'b0;
      end else begin
         unique case (state_q)
            StA: if (press_q) begin
               a_d     = in_number;
               state_d = StOp;
            end
            StOp: if (press_q) begin
               op_d    = op_sel;
               state_d = StB;
            end
            StB: if (press_q) begin
               b_d       = in_number;
               rem_d     = '0;
               quo_d     = a_q;
               div_cnt_d = '0;
               state_d   = StExec;
            end
            StExec: begin
               state_d = StShow;
               case (op_q)
                  2'b00: result_d = RW'(a_q) + RW'(b_q);
                  2'b01: begin
                     result_d = (a_q < b_q) ? RW'(b_q - a_q) : RW'(a_q - b_q);
                     neg_d    = (a_q < b_q);
                  end
                  2'b10: result_d = RW'(a_q) * RW'(b_q);
                  default: begin
                     if (b_q == '0) begin
                        err_d    = 1'b1;
                        result_d = '0;
                     end else begin
                        // No borrow means the shifted partial remainder covers the divisor.
                        if (!div_sub[WIDTH]) begin
                           rem_d = div_sub[WIDTH-1:0];
                           quo_d = (quo_q << 1) | WIDTH'(1);
                        end else begin
                           rem_d = div_shift[WIDTH-1:0];
                           quo_d = quo_q << 1;
                        end
                        if (div_cnt_q == CW'(WIDTH - 1)) begin
                           result_d = {rem_d, quo_d};
                        end else begin
                           div_cnt_d = div_cnt_q + CW'(1);
                           state_d   = StExec;
                        end
                     end
                  end
               endcase
            end
            StShow: if (press_q) begin
               neg_d   = 1'b0;
               err_d   = 1'b0;
               state_d = StA;
            end
            default: state_d = StA;
         endcase
      end

      case (state_d)
         StA, StB: disp_d = RW'(in_number);
         StOp:     disp_d = RW'(a_d);
         StShow:   disp_d = result_d;
         default:  disp_d = disp_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StA;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         result_q  <= '0;
         disp_q    <= '0;
         neg_q     <= 1'b0;
         err_q     <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         result_q  <= result_d;
         disp_q    <= disp_d;
         neg_q     <= neg_d;
         err_q     <= err_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   assign disp_data = disp_q;
   assign led       = state_q;
   assign busy      = (state_q == StExec);
   assign neg       = neg_q;
   assign err       = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized bench for calc_seq_ctrl: drives whole A/op/B transactions through the keys
// and compares display, flags, led and busy length with an arithmetic reference model.
module tb_calc_seq_ctrl;
   localparam int W = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [W-1:0]   in_number;
   logic [1:0]     op_sel;
   logic           k_enter, k_clr;
   logic [2*W-1:0] disp_data;
   logic [2:0]     led;
   logic           busy, neg, err;

   int n_vec = 0;
   int n_err = 0;
   int unsigned busy_total = 0;

   calc_seq_ctrl #(.WIDTH(W), .DEB_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_number (in_number),
      .op_sel    (op_sel),
      .k_enter   (k_enter),
      .k_clr     (k_clr),
      .disp_data (disp_data),
      .led       (led),
      .busy      (busy),
      .neg       (neg),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) busy_total <= busy_total + 32'(busy);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_result(input int a, input int op, input int b);
      case (op)
         0:       return (2*W)'(a + b);
         1:       return (2*W)'((a > b) ? a - b : b - a);
         2:       return (2*W)'(a * b);
         default: return (b == 0) ? '0 : (2*W)'(((a % b) << W) | (a / b));
      endcase
   endfunction

   // Clean press; in_number is scrambled while the key is still held.
   task automatic press_key();
      k_enter = 1'b1;
      repeat (8) @(negedge clk);
      in_number = W'($urandom);
      repeat (4) @(negedge clk);
      k_enter = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic bounce_press();
      k_enter = 1'b0;
      for (int i = 0; i < 5; i++) begin
         k_enter = ~k_enter;
         repeat (2) @(negedge clk);
      end
      k_enter = 1'b1;
      repeat (20) @(negedge clk);
      k_enter = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic do_op(input int a, input int op, input int b, input bit bounce,
                        input bit stay);
      int unsigned b0;
      logic [2*W-1:0] exp_res;
      int exp_busy;
      exp_res  = ref_result(a, op, b);
      exp_busy = (op == 3 && b != 0) ? W : 1;
      check_val("idle_led", led, 3'b001);
      in_number = W'(a);
      repeat (2) @(negedge clk);
      check_val("a_live_disp", disp_data, a);
      if (bounce) bounce_press();
      else press_key();
      check_val("op_led", led, 3'b010);
      check_val("op_disp_a", disp_data, a);
      op_sel = 2'(op);
      press_key();
      check_val("b_led", led, 3'b011);
      in_number = W'(b);
      repeat (2) @(negedge clk);
      check_val("b_live_disp", disp_data, b);
      b0 = busy_total;
      press_key();
      check_val("show_led", led, 3'b101);
      check_val("busy_cycles", busy_total - b0, exp_busy);
      check_val("busy_low", busy, 1'b0);
      check_val("result", disp_data, exp_res);
      check_val("neg", neg, (op == 1 && a < b));
      check_val("err", err, (op == 3 && b == 0));
      if (!stay) begin
         press_key();
         check_val("back_led", led, 3'b001);
         check_val("back_flags", {neg, err}, 2'b00);
         check_val("back_disp", disp_data, in_number);
      end
   endtask

   task automatic pulse_clr();
      k_clr = 1'b1;
      repeat (4) @(negedge clk);
      k_clr = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int unsigned b0, d;
      rst_n = 1'b0; k_enter = 1'b0; k_clr = 1'b0; in_number = '0; op_sel = '0;
      repeat (3) @(negedge clk);
      check_val("rst_led", led, 3'b001);
      check_val("rst_disp", disp_data, 0);
      check_val("rst_flags", {busy, neg, err}, 3'b000);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      do_op(7, 0, 9, 1'b1, 1'b0);
      do_op(3, 1, 5, 1'b0, 1'b1);
      pulse_clr();
      check_val("clr_show_led", led, 3'b001);
      check_val("clr_show_neg", neg, 1'b0);
      do_op(15, 2, 15, 1'b0, 1'b0);
      do_op(13, 3, 4, 1'b0, 1'b0);
      do_op(9, 3, 0, 1'b0, 1'b1);
      pulse_clr();
      check_val("clr_show_err", err, 1'b0);
      check_val("clr_show_led2", led, 3'b001);

      // Clear lands while 13/4 is still iterating.
      in_number = 4'd13;
      repeat (2) @(negedge clk);
      press_key();
      op_sel = 2'd3;
      press_key();
      in_number = 4'd4;
      b0 = busy_total;
      k_enter = 1'b1;
      repeat (6) @(negedge clk);
      k_clr = 1'b1;
      repeat (6) @(negedge clk);
      k_enter = 1'b0;
      repeat (12) @(negedge clk);
      check_val("clr_div_led", led, 3'b001);
      k_clr = 1'b0;
      repeat (3) @(negedge clk);
      d = busy_total - b0;
      check_val("clr_div_aborted", (d >= 1 && d < W), 1);
      check_val("clr_div_led2", led, 3'b001);
      check_val("clr_div_flags", {busy, neg, err}, 3'b000);
      check_val("clr_div_disp", disp_data, 4);

      // Press while clear is held must not advance.
      k_clr = 1'b1;
      repeat (3) @(negedge clk);
      press_key();
      check_val("clr_wins_led", led, 3'b001);
      k_clr = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         do_op(int'($urandom_range(15)), int'($urandom_range(3)),
               int'($urandom_range(15)), 1'b0, 1'b0);
      end

      // Asynchronous reset in S_OP.
      in_number = 4'd5;
      repeat (2) @(negedge clk);
      press_key();
      check_val("pre_rst_led", led, 3'b010);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_led", led, 3'b001);
      check_val("async_rst_disp", disp_data, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Asynchronous reset mid-division.
      in_number = 4'd14;
      repeat (2) @(negedge clk);
      press_key();
      op_sel = 2'd3;
      press_key();
      in_number = 4'd3;
      k_enter = 1'b1;
      repeat (8) @(negedge clk);
      check_val("mid_div_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("rst_div_busy", busy, 1'b0);
      check_val("rst_div_led", led, 3'b001);
      k_enter = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_op(14, 3, 3, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
